sdram_burst_master: RTL and testbench

// - FPGA-side Avalon-MM burst initiator for one f2h_sdram port of the HPS bridge (64-bit port 1/2 profile).
// - Turns a single (addr, len, dir) command into aligned Avalon bursts.
// - Read data is streamed out; write data is pulled from a valid/ready stream.
// - Used by save-state / ROM-load DMA logic; one command in flight at a time.

---
 rtl/sdram_burst_master_if.sv | 41 ++++
 rtl/sdram_burst_master.sv | 155 +++++++++++++++
 tb/tb_sdram_burst_master.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_burst_master_if.sv
// Command, write-stream, read-stream and Avalon-MM signal bundle for sdram_burst_master.
// The master modport is the burst engine's view; slave is the surrounding logic and memory.
interface sdram_burst_master_if #(
  parameter int unsigned ADDR_W = 29,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [LEN_W-1:0]      cmd_len;
  logic [DATA_W-1:0]     wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic [ADDR_W-1:0]     avm_address;
  logic [7:0]            avm_burstcount;
  logic                  avm_read;
  logic                  avm_write;
  logic [DATA_W-1:0]     avm_writedata;
  logic [DATA_W/8-1:0]   avm_byteenable;
  logic                  avm_waitrequest;
  logic [DATA_W-1:0]     avm_readdata;
  logic                  avm_readdatavalid;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    output cmd_ready, wr_ready, rd_data, rd_valid,
    output avm_address, avm_burstcount, avm_read, avm_write, avm_writedata, avm_byteenable
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  cmd_ready, wr_ready, rd_data, rd_valid,
    input  avm_address, avm_burstcount, avm_read, avm_write, avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/sdram_burst_master.sv
// Avalon-MM burst initiator: splits one (addr, len, dir) command into BURST_MAX-aligned bursts.
// Optional stall counter enabled by defining SDRAM_BURST_MASTER_STATS_EN.
module sdram_burst_master #(
  parameter int unsigned ADDR_W    = 29,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned BURST_MAX = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sdram_burst_master_if.master bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [31:0]          stall_cycles_o
);

  typedef enum logic [2:0] {StIdle, StSetup, StRdReq, StRdData, StWrBurst, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [7:0]        bcount_q, bcount_d;
  logic [7:0]        beat_q, beat_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [ADDR_W-1:0] offs;
  logic [8:0]        space;
  logic [7:0]        blen;
  logic              avm_read, avm_write, accept;

  // Beats left before the next BURST_MAX boundary, clipped to what remains of the command.
  always_comb begin
    offs  = addr_q & ADDR_W'(BURST_MAX - 1);
    space = 9'(BURST_MAX) - 9'(offs);
    if (32'(rem_q) < 32'(space)) blen = 8'(rem_q);
    else                         blen = 8'(space);
  end

  assign accept    = (state_q == StIdle) && bus.cmd_valid;
  assign avm_read  = (state_q == StRdReq);
  assign avm_write = (state_q == StWrBurst) && bus.wr_valid;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    write_d   = write_q;
    address_d = address_q;
    bcount_d  = bcount_q;
    beat_d    = beat_q;
    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          rem_d   = bus.cmd_len;
          write_d = bus.cmd_write;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (rem_q == '0) begin
          state_d = StDone;
        end else begin
          address_d = addr_q;
          bcount_d  = blen;
          addr_d    = addr_q + ADDR_W'(blen);
          rem_d     = rem_q - LEN_W'(blen);
          beat_d    = '0;
          state_d   = write_q ? StWrBurst : StRdReq;
        end
      end
      StRdReq: begin
        if (!bus.avm_waitrequest) state_d = StRdData;
      end
      StRdData: begin
        if (bus.avm_readdatavalid) begin
          beat_d = beat_q + 8'd1;
          if (beat_d == bcount_q) state_d = (rem_q != '0) ? StSetup : StDone;
        end
      end
      StWrBurst: begin
        if (bus.wr_valid && !bus.avm_waitrequest) begin
          beat_d = beat_q + 8'd1;
          if (beat_d == bcount_q) state_d = (rem_q != '0) ? StSetup : StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rem_q     <= '0;
      write_q   <= 1'b0;
      address_q <= '0;
      bcount_q  <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      write_q   <= write_d;
      address_q <= address_d;
      bcount_q  <= bcount_d;
      beat_q    <= beat_d;
    end
  end

  // Read beats are only forwarded while a burst is outstanding; strays are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= (state_q == StRdData) && bus.avm_readdatavalid;
      if ((state_q == StRdData) && bus.avm_readdatavalid) rd_data_q <= bus.avm_readdata;
    end
  end

`ifdef SDRAM_BURST_MASTER_STATS_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if ((avm_read || avm_write) && bus.avm_waitrequest && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end
  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = 32'd0;
`endif

  assign bus.cmd_ready      = (state_q == StIdle);
  assign bus.wr_ready       = (state_q == StWrBurst) && !bus.avm_waitrequest;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.rd_data        = rd_data_q;
  assign bus.avm_address    = address_q;
  assign bus.avm_burstcount = bcount_q;
  assign bus.avm_read       = avm_read;
  assign bus.avm_write      = avm_write;
  assign bus.avm_writedata  = bus.wr_data;
  assign bus.avm_byteenable = '1;
  assign busy_o             = (state_q != StIdle);
  assign done_o             = (state_q == StDone);

endmodule

// File: tb/tb_sdram_burst_master.sv
// Directed bench for sdram_burst_master: command table plus reset and stray-data sequences.
module tb_sdram_burst_master;
  localparam int unsigned ADDR_W = 29;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned LEN_W  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy, done;
  logic [31:0] stall_cycles;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  sdram_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  sdram_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .BURST_MAX(64)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .bus            (bus),
    .busy_o         (busy),
    .done_o         (done),
    .stall_cycles_o (stall_cycles)
  );

  // wmode: 0 no waitrequest, 1 random waitrequest, 2 waitrequest held for 'hold' read cycles
  typedef struct {
    logic        wr;
    logic [28:0] addr;
    logic [15:0] len;
    int          wmode;
    int          hold;
    int          nb;
    logic [28:0] ba0, ba1, ba2;
    logic [7:0]  bc0, bc1, bc2;
  } vec_t;

  vec_t        vecs[8];
  logic [28:0] got_a[$];
  logic [7:0]  got_c[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] pat(input int k);
    return {32'(k) ^ 32'hDEADBEEF, 32'h0BAD0000 | 32'(k)};
  endfunction

  function automatic vec_t mk(input logic wr, input logic [28:0] addr, input logic [15:0] len,
                              input int wmode, input int hold, input int nb,
                              input logic [28:0] ba0, input logic [7:0] bc0,
                              input logic [28:0] ba1, input logic [7:0] bc1,
                              input logic [28:0] ba2, input logic [7:0] bc2);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.wmode = wmode; v.hold = hold; v.nb = nb;
    v.ba0 = ba0; v.bc0 = bc0; v.ba1 = ba1; v.bc1 = bc1; v.ba2 = ba2; v.bc2 = bc2;
    return v;
  endfunction

  task automatic run_cmd(input vec_t v, input int abort_rd, output bit aborted);
    int rd_left = 0, rd_drv = 0, rd_seen = 0, wr_idx = 0, wr_left = 0;
    int done_cnt = 0, done_cyc = -1, data_err = 0, wrr_err = 0, stab_err = 0;
    int act_cyc = 0, stall_model = 0, hold_left = v.hold;
    logic [28:0] cur_a = '0, ea;
    logic [7:0]  cur_c = '0, ec;
    bit stop = 1'b0;
    longint exp_stall;
    aborted = 1'b0;
    got_a.delete();
    got_c.delete();
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = v.wr; bus.cmd_addr = v.addr; bus.cmd_len = v.len;
    #1;
    check("cmd_ready_before_accept", bus.cmd_ready, 1);
    check("busy_before_accept", busy, 0);
    @(posedge clk);
    for (int cyc = 1; cyc < 3000 && !stop; cyc++) begin
      @(negedge clk);
      // Inputs after accept must have no effect.
      bus.cmd_valid = 1'b0; bus.cmd_addr = 29'h0AAAAAAA; bus.cmd_len = 16'hFFFF;
      bus.cmd_write = ~v.wr;
      case (v.wmode)
        1:       bus.avm_waitrequest = ($urandom_range(0, 2) == 0);
        2:       bus.avm_waitrequest = (hold_left > 0);
        default: bus.avm_waitrequest = 1'b0;
      endcase
      if (rd_left > 0 && $urandom_range(0, 3) != 0) begin
        bus.avm_readdatavalid = 1'b1; bus.avm_readdata = pat(rd_drv);
        rd_drv++; rd_left--;
      end else begin
        bus.avm_readdatavalid = 1'b0; bus.avm_readdata = '0;
      end
      bus.wr_valid = v.wr && ($urandom_range(0, 2) != 0);
      bus.wr_data  = pat(wr_idx);
      #1;
      if (done_cnt > 0 && !done) begin
        check("cmd_ready_after_done", bus.cmd_ready, 1);
        check("busy_after_done", busy, 0);
        stop = 1'b1;
      end
      if (bus.rd_valid) begin
        if (bus.rd_data !== pat(rd_seen)) data_err++;
        rd_seen++;
      end
      if (bus.avm_read || bus.avm_write) act_cyc++;
      if ((bus.avm_read || bus.avm_write) && bus.avm_waitrequest) stall_model++;
      if (bus.wr_ready && bus.avm_waitrequest) wrr_err++;
      if (bus.avm_read && bus.avm_waitrequest && hold_left > 0) hold_left--;
      if (bus.avm_read && !bus.avm_waitrequest) begin
        got_a.push_back(bus.avm_address); got_c.push_back(bus.avm_burstcount);
        rd_left += int'(bus.avm_burstcount);
      end
      if (wr_left > 0 && (bus.avm_address !== cur_a || bus.avm_burstcount !== cur_c)) stab_err++;
      if (bus.avm_write) begin
        if (wr_left == 0) begin
          cur_a = bus.avm_address; cur_c = bus.avm_burstcount;
          got_a.push_back(cur_a); got_c.push_back(cur_c);
          wr_left = int'(cur_c);
        end
        if (!bus.avm_waitrequest) begin
          if (bus.avm_writedata !== pat(wr_idx)) data_err++;
          wr_idx++; wr_left--;
        end
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = cyc;
          check("busy_at_done", busy, 1);
`ifdef SDRAM_BURST_MASTER_STATS_EN
          exp_stall = (v.hold > 0) ? longint'(v.hold) : longint'(stall_model);
`else
          exp_stall = 0;
`endif
          check("stall_cycles", stall_cycles, 64'(exp_stall));
        end
      end
      if (abort_rd > 0 && rd_seen >= abort_rd) begin
        aborted = 1'b1; stop = 1'b1;
      end
      if (!stop) @(posedge clk);
    end
    bus.avm_readdatavalid = 1'b0; bus.wr_valid = 1'b0; bus.avm_waitrequest = 1'b0;
    if (!aborted) begin
      check("done_pulses", done_cnt, 1);
      check("burst_count", got_a.size(), v.nb);
      for (int i = 0; i < v.nb && i < got_a.size(); i++) begin
        ea = (i == 0) ? v.ba0 : (i == 1) ? v.ba1 : v.ba2;
        ec = (i == 0) ? v.bc0 : (i == 1) ? v.bc1 : v.bc2;
        check($sformatf("burst%0d_addr", i), got_a[i], ea);
        check($sformatf("burst%0d_len", i), got_c[i], ec);
      end
      check("beats", v.wr ? wr_idx : rd_seen, v.len);
      check("data_order_errors", data_err, 0);
      check("wr_ready_during_wait", wrr_err, 0);
      check("wr_addr_stability", stab_err, 0);
      if (v.len == 0) begin
        check("null_done_latency", done_cyc, 2);
        check("null_avalon_activity", act_cyc, 0);
      end
    end
  endtask

  initial begin
    bit ab;
    int stray;
    vecs[0] = mk(0, 29'h100, 100'd0 + 16'd4, 0, 0, 1, 29'h100, 8'd4, 29'h0, 8'd0, 29'h0, 8'd0);
    vecs[1] = mk(0, 29'h3C, 16'd100, 1, 0, 3, 29'h3C, 8'd4, 29'h40, 8'd64, 29'h80, 8'd32);
    vecs[2] = mk(1, 29'h0, 16'd8, 1, 0, 1, 29'h0, 8'd8, 29'h0, 8'd0, 29'h0, 8'd0);
    vecs[3] = mk(0, 29'h55, 16'd0, 0, 0, 0, 29'h0, 8'd0, 29'h0, 8'd0, 29'h0, 8'd0);
    vecs[4] = mk(0, 29'h1FFFFFFE, 16'd3, 1, 0, 2, 29'h1FFFFFFE, 8'd2, 29'h0, 8'd1, 29'h0, 8'd0);
    vecs[5] = mk(1, 29'h7F, 16'd2, 1, 0, 2, 29'h7F, 8'd1, 29'h80, 8'd1, 29'h0, 8'd0);
    vecs[6] = mk(0, 29'h40, 16'd5, 2, 10, 1, 29'h40, 8'd5, 29'h0, 8'd0, 29'h0, 8'd0);
    vecs[7] = mk(1, 29'h3F0, 16'd70, 1, 0, 2, 29'h3F0, 8'd16, 29'h400, 8'd54, 29'h0, 8'd0);

    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_data = '0; bus.wr_valid = 0; bus.avm_waitrequest = 0;
    bus.avm_readdata = '0; bus.avm_readdatavalid = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_avm_read", bus.avm_read, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_avm_address", bus.avm_address, 0);
    check("rst_avm_burstcount", bus.avm_burstcount, 0);
    check("rst_stall", stall_cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_cmd_ready", bus.cmd_ready, 1);
    check("idle_wr_ready", bus.wr_ready, 0);
    check("idle_rd_valid", bus.rd_valid, 0);
    check("byteenable", bus.avm_byteenable, 8'hFF);

    foreach (vecs[i]) run_cmd(vecs[i], 0, ab);

    // Reset in the middle of a read burst, then stray read data while idle.
    run_cmd(mk(0, 29'h200, 16'd16, 0, 0, 1, 29'h200, 8'd16, 29'h0, 8'd0, 29'h0, 8'd0), 2, ab);
    check("abort_reached_rd_data", ab, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rd_valid", bus.rd_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_avm_read", bus.avm_read, 0);
    check("midrst_avm_burstcount", bus.avm_burstcount, 0);
    check("midrst_cmd_ready", bus.cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.avm_readdatavalid = 1'b1; bus.avm_readdata = 64'hFFFF_0000_FFFF_0000;
      #1;
      if (bus.rd_valid || busy) stray++;
    end
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    #1;
    check("stray_rd_valid_or_busy", stray + int'(bus.rd_valid), 0);
    run_cmd(vecs[0], 0, ab);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
